// File: rtl/guess_game_ctrl.sv
// Round sequencer for the LED guessing game: tick generation, round restart, score/miss/level tally.
// Optional GUESS_PAUSE_EN adds a pause input that freezes the tick divider while a round is playing.
module guess_game_ctrl #(
  parameter int CNT_W      = 24,
  parameter int BASE_DIV   = 10000000,
  parameter int DIV_STEP   = 1000000,
  parameter int NUM_LEVELS = 8,
  parameter int ROUNDS     = 5,
  parameter int HOLD_CYC   = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] btn,
  input  logic       win,
  input  logic       lose,
`ifdef GUESS_PAUSE_EN
  input  logic       pause,
`endif
  output logic       tick,
  output logic       guess_rst,
  output logic [3:0] score,
  output logic [3:0] misses,
  output logic [2:0] level,
  output logic       busy,
  output logic       game_over
);

  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [2:0] {IDLE, PLAY, RESULT, WAIT_REL, DONE} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  div_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic [3:0]        round_reg;
  logic              skip_reg;
  logic              tick_reg;
  logic              guess_rst_reg;
  logic [3:0]        score_reg;
  logic [3:0]        misses_reg;
  logic [2:0]        level_reg;
  logic              busy_reg;
  logic              game_over_reg;

  // Terminal divider count per level; unused slots repeat the fastest level.
  logic [CNT_W-1:0] div_last [8];
  for (genvar gi = 0; gi < 8; gi++) begin : g_div
    localparam int LV = (gi < NUM_LEVELS) ? gi : NUM_LEVELS - 1;
    assign div_last[gi] = CNT_W'(BASE_DIV - 1 - LV * DIV_STEP);
  end

  logic run;
`ifdef GUESS_PAUSE_EN
  assign run = !pause;
`else
  assign run = 1'b1;
`endif

  // The guess FSM is still settling in the restart cycle and the one after it.
  logic accept;
  assign accept = !guess_rst_reg && !skip_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      div_reg       <= '0;
      hold_reg      <= '0;
      round_reg     <= '0;
      skip_reg      <= 1'b0;
      tick_reg      <= 1'b0;
      guess_rst_reg <= 1'b0;
      score_reg     <= '0;
      misses_reg    <= '0;
      level_reg     <= '0;
      busy_reg      <= 1'b0;
      game_over_reg <= 1'b0;
    end else begin
      tick_reg      <= 1'b0;
      guess_rst_reg <= 1'b0;
      skip_reg      <= guess_rst_reg;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            score_reg     <= '0;
            misses_reg    <= '0;
            level_reg     <= '0;
            round_reg     <= '0;
            div_reg       <= '0;
            guess_rst_reg <= 1'b1;
            busy_reg      <= 1'b1;
            game_over_reg <= 1'b0;
            state_reg     <= PLAY;
          end
        end
        PLAY: begin
          if (accept && (win || lose)) begin
            if (lose) begin
              if (misses_reg != 4'd15) misses_reg <= misses_reg + 4'd1;
            end else begin
              if (score_reg != 4'd15) score_reg <= score_reg + 4'd1;
              if (level_reg != 3'(NUM_LEVELS - 1)) level_reg <= level_reg + 3'd1;
            end
            round_reg <= round_reg + 4'd1;
            hold_reg  <= '0;
            state_reg <= RESULT;
          end else if (run) begin
            if (div_reg == div_last[level_reg]) begin
              div_reg  <= '0;
              tick_reg <= 1'b1;
            end else begin
              div_reg <= div_reg + 1'b1;
            end
          end
        end
        RESULT: begin
          if (hold_reg == HOLD_W'(HOLD_CYC - 1)) state_reg <= WAIT_REL;
          else hold_reg <= hold_reg + 1'b1;
        end
        WAIT_REL: begin
          if (btn == 4'b0000) begin
            if (round_reg == 4'(ROUNDS)) begin
              busy_reg      <= 1'b0;
              game_over_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              div_reg       <= '0;
              guess_rst_reg <= 1'b1;
              state_reg     <= PLAY;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign tick      = tick_reg;
  assign guess_rst = guess_rst_reg;
  assign score     = score_reg;
  assign misses    = misses_reg;
  assign level     = level_reg;
  assign busy      = busy_reg;
  assign game_over = game_over_reg;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Randomized bench for guess_game_ctrl against a round-level behavioural model.
module tb_guess_game_ctrl;

  localparam int BASE_DIV   = 8;
  localparam int DIV_STEP   = 2;
  localparam int NUM_LEVELS = 4;
  localparam int ROUNDS     = 3;
  localparam int HOLD_CYC   = 4;

  localparam int M_IDLE = 0, M_PLAY = 1, M_RES = 2, M_WAIT = 3, M_DONE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] btn = 4'd0;
  logic       win = 1'b0;
  logic       lose = 1'b0;
  logic       pause = 1'b0;
  logic       tick, guess_rst, busy, game_over;
  logic [3:0] score, misses;
  logic [2:0] level;

  int checks = 0;
  int failures = 0;

  // Model state: mode, tallies, cycles since restart (age) and unpaused cycles (run).
  int m_mode = M_IDLE, m_score = 0, m_miss = 0, m_level = 0, m_round = 0;
  int m_age = 0, m_run = 0, m_hold = 0;
  bit m_tick = 0, m_grst = 0;

  always #5 clk = ~clk;

  guess_game_ctrl #(
    .CNT_W(8), .BASE_DIV(BASE_DIV), .DIV_STEP(DIV_STEP),
    .NUM_LEVELS(NUM_LEVELS), .ROUNDS(ROUNDS), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .btn(btn), .win(win), .lose(lose),
`ifdef GUESS_PAUSE_EN
    .pause(pause),
`endif
    .tick(tick), .guess_rst(guess_rst), .score(score), .misses(misses),
    .level(level), .busy(busy), .game_over(game_over)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit [3:0] b,
                            input bit w, input bit l, input bit p);
    int dv;
    m_tick = 0;
    m_grst = 0;
    if (r) begin
      m_mode = M_IDLE; m_score = 0; m_miss = 0; m_level = 0; m_round = 0;
      return;
    end
    dv = BASE_DIV - m_level * DIV_STEP;
    case (m_mode)
      M_IDLE, M_DONE: if (s) begin
        m_score = 0; m_miss = 0; m_level = 0; m_round = 0;
        m_mode = M_PLAY; m_grst = 1; m_age = 0; m_run = 0;
      end
      M_PLAY: begin
        if (m_age >= 2 && (w || l)) begin
          m_round++;
          if (l) m_miss = (m_miss < 15) ? m_miss + 1 : 15;
          else begin
            m_score = (m_score < 15) ? m_score + 1 : 15;
            m_level = (m_level < NUM_LEVELS - 1) ? m_level + 1 : NUM_LEVELS - 1;
          end
          $display("round %0d %s score=%0d misses=%0d level=%0d", m_round,
                   l ? "lost" : "won", m_score, m_miss, m_level);
          m_mode = M_RES;
          m_hold = 1;
        end else begin
          m_age++;
          if (!p) begin
            m_run++;
            m_tick = (m_run % dv) == 0;
          end
        end
      end
      M_RES: if (m_hold == HOLD_CYC) m_mode = M_WAIT; else m_hold++;
      M_WAIT: if (b == 4'd0) begin
        if (m_round == ROUNDS) m_mode = M_DONE;
        else begin
          m_mode = M_PLAY; m_grst = 1; m_age = 0; m_run = 0;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // One clock: drive at the falling edge, compare just after the rising edge.
  task automatic step(input bit r, input bit s, input bit [3:0] b,
                      input bit w, input bit l, input bit p);
    @(negedge clk);
    rst = r; start = s; btn = b; win = w; lose = l; pause = p;
    model_step(r, s, b, w, l, p);
    @(posedge clk);
    #1;
    check_eq("tick", int'(tick), int'(m_tick));
    check_eq("guess_rst", int'(guess_rst), int'(m_grst));
    check_eq("score", int'(score), m_score);
    check_eq("misses", int'(misses), m_miss);
    check_eq("level", int'(level), m_level);
    check_eq("busy", int'(busy), int'(m_mode == M_PLAY || m_mode == M_RES || m_mode == M_WAIT));
    check_eq("game_over", int'(game_over), int'(m_mode == M_DONE));
  endtask

  task automatic play_round(input bit w, input bit l);
    repeat (11) step(0, 0, 4'd0, 0, 0, 0);
    step(0, 0, 4'd0, w, l, 0);
    repeat (6) step(0, 0, 4'h3, 0, 0, 0);
    step(0, 0, 4'd0, 0, 0, 0);
  endtask

  initial begin
    bit r, s, w, l, p;
    bit [3:0] b;
    repeat (2) step(1, 0, 4'd0, 0, 0, 0);
    step(0, 1, 4'd0, 0, 0, 0);
    repeat (20) step(0, 0, 4'd0, 0, 0, 0);
    play_round(1, 0);
    play_round(1, 0);
    play_round(1, 0);
    repeat (5) step(0, 0, 4'd0, 0, 0, 0);
    step(0, 1, 4'd0, 0, 0, 0);
    play_round(1, 1);
    play_round(1, 0);
    repeat (11) step(0, 0, 4'd0, 0, 0, 0);
    step(0, 0, 4'd0, 1, 0, 0);
    step(0, 0, 4'd0, 0, 0, 0);
    step(1, 0, 4'd0, 0, 0, 0);
    step(1, 1, 4'd0, 0, 0, 0);
    step(0, 0, 4'd0, 0, 0, 0);
`ifdef GUESS_PAUSE_EN
    step(0, 1, 4'd0, 0, 0, 0);
    repeat (4) step(0, 0, 4'd0, 0, 0, 0);
    repeat (20) step(0, 0, 4'd0, 0, 0, 1);
    repeat (12) step(0, 0, 4'd0, 0, 0, 0);
`endif
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 399) == 0);
      s = ($urandom_range(0, 7) == 0);
      b = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      w = ($urandom_range(0, 9) == 0);
      l = ($urandom_range(0, 11) == 0);
`ifdef GUESS_PAUSE_EN
      p = ($urandom_range(0, 3) == 0);
`else
      p = 0;
`endif
      step(r, s, b, w, l, p);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
